// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the display
// scan-out and a host write port. Display reads own every active even-column
// cycle; all other cycles are host slots that drain a one-entry write buffer.
// Pixels come out two cycles after their column is presented, with matching
// delayed blanking/sync strobes.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FB_WORDS = 153600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] row,
  input  logic [15:0] col,
  input  logic        in_video,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [17:0] host_addr,
  input  logic [15:0] host_data,
  input  logic [1:0]  host_be,
  output logic [17:0] ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [7:0]  pix,
  output logic        pix_de,
  output logic        pix_hsync,
  output logic        pix_vsync
);

  localparam logic [15:0] H_LIM    = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM    = 16'(V_ACTIVE);
  localparam logic [17:0] HALF_W   = 18'(H_ACTIVE / 2);
  localparam logic [18:0] FB_LIMIT = 19'(FB_WORDS);

  // Words per line is a constant, so the row multiply reduces to a fixed set
  // of shifted adds (two terms for a 640-pixel line).
  function automatic logic [17:0] line_base(input logic [15:0] r);
    logic [17:0] acc;
    acc = '0;
    for (int i = 0; i < 18; i++) begin
      if (HALF_W[i]) acc = acc + (18'(r) << i);
    end
    return acc;
  endfunction

  logic        active;
  logic        rd_cycle;
  logic        drain;
  logic        in_range;
  logic [17:0] rd_addr;

  logic        buf_full;
  logic [17:0] buf_addr;
  logic [15:0] buf_data;
  logic [1:0]  buf_be;
  logic [17:0] last_addr;

  logic [15:0] word;
  logic        rd_d1;
  logic        col0_d1;
  logic        active_d1;
  logic        hsync_d1;
  logic        vsync_d1;

  // Slot classification: even active columns read, everything else is host.
  always_comb begin
    active   = in_video && (col < H_LIM) && (row < V_LIM);
    rd_cycle = active && !col[0];
    rd_addr  = line_base(row) + {9'd0, col[9:1]};
    in_range = {1'b0, buf_addr} < FB_LIMIT;
    drain    = rst_n && buf_full && !rd_cycle;
    host_ready = rst_n && !buf_full;
  end

  // RAM command mux; idle host slots keep the last address on the bus.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    ram_we    = 1'b0;
    ram_be    = 2'b00;
    ram_addr  = last_addr;
    ram_wdata = buf_data;
    if (!rst_n) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (rd_cycle) begin
      ram_addr = rd_addr;
    end else if (drain && in_range) begin
      ram_we   = 1'b1;
      ram_be   = buf_be;
      ram_addr = buf_addr;
    end
  end

  // One-entry host write buffer: capture when empty, drain in the next host slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the buffer payload is cleared too, because ram_wdata is driven
      // straight from it and must read zero out of reset.
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      buf_be   <= '0;
    end else if (drain) begin
      buf_full <= 1'b0;
    end else if (host_valid && host_ready) begin
      buf_full <= 1'b1;
      buf_addr <= host_addr;
      buf_data <= host_data;
      buf_be   <= host_be;
    end
  end

  // Remember the address presented this cycle so idle slots can hold it.
  always_ff @(posedge clk) begin
    if (!rst_n) last_addr <= '0;
    else        last_addr <= ram_addr;
  end

  // Two-stage display pipeline: read data arrives in stage 1, pixel in stage 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_d1     <= 1'b0;
      col0_d1   <= 1'b0;
      active_d1 <= 1'b0;
      hsync_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      word      <= '0;
      pix       <= '0;
      pix_de    <= 1'b0;
      pix_hsync <= 1'b0;
      pix_vsync <= 1'b0;
    end else begin
      rd_d1     <= rd_cycle;
      col0_d1   <= col[0];
      active_d1 <= active;
      hsync_d1  <= hsync;
      vsync_d1  <= vsync;
      if (rd_d1) word <= ram_rdata;
      // Even pixel bypasses the word register since its data is on ram_rdata now.
      if (!active_d1)   pix <= 8'h00;
      else if (col0_d1) pix <= word[15:8];
      else              pix <= ram_rdata[7:0];
      pix_de    <= active_d1;
      pix_hsync <= hsync_d1;
      pix_vsync <= vsync_d1;
    end
  end

endmodule
